fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 149 ++++++++++++++
 tb/tb_fetch_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding instruction-memory
// request FSM, and the IF/ID pipeline register with a skid buffer for stalls.
module fetch_stage #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  StallF,
   input  logic                  StallD,
   input  logic                  FlushD,
   input  logic                  PCSrcE,
   input  logic [DATA_WIDTH-1:0] PCTargetE,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [DATA_WIDTH-1:0] instrD,
   output logic [DATA_WIDTH-1:0] PCD,
   output logic [DATA_WIDTH-1:0] PCPlus4D,
   output logic                  validD
);

   localparam logic [DATA_WIDTH-1:0] NOP   = DATA_WIDTH'(32'h0000_0013);
   localparam logic [DATA_WIDTH-1:0] FOUR  = DATA_WIDTH'(4);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t                state_q, state_d, next_ps;
   logic [DATA_WIDTH-1:0] pcf_q, pcf_d;
   logic                  discard_q, discard_d;
   logic [DATA_WIDTH-1:0] pc_pend_q, pc_pend_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic [DATA_WIDTH-1:0] pcd_q, pcd_d;
   logic [DATA_WIDTH-1:0] pcp4_q, pcp4_d;
   logic                  valid_q, valid_d;
   logic                  req_c;
   logic                  load_c;
   logic [DATA_WIDTH-1:0] load_word_c;

   always_comb begin
      state_d     = state_q;
      pcf_d       = pcf_q;
      discard_d   = discard_q;
      pc_pend_d   = pc_pend_q;
      skid_d      = skid_q;
      req_c       = 1'b0;
      load_c      = 1'b0;
      load_word_c = imem_rdata;
      next_ps     = StallF ? IDLE : REQ;

      unique case (state_q)
         IDLE: begin
            if (!StallF) state_d = REQ;
         end
         REQ: begin
            req_c = !StallF;
            if (req_c && imem_gnt) begin
               pc_pend_d = pcf_q;
               pcf_d     = pcf_q + FOUR;
               discard_d = PCSrcE;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            if (PCSrcE) discard_d = 1'b1;
            // A redirect in the same cycle as the response makes it wrong-path too.
            if (imem_rvalid) begin
               if (discard_q || PCSrcE) begin
                  discard_d = 1'b0;
                  state_d   = next_ps;
               end else if (StallD) begin
                  skid_d  = imem_rdata;
                  state_d = HOLD;
               end else begin
                  load_c  = 1'b1;
                  state_d = next_ps;
               end
            end
         end
         HOLD: begin
            if (PCSrcE) begin
               state_d = REQ;
            end else if (!StallD) begin
               load_c      = 1'b1;
               load_word_c = skid_q;
               state_d     = next_ps;
            end
         end
         default: state_d = IDLE;
      endcase

      if (PCSrcE) pcf_d = PCTargetE;
   end

   always_comb begin
      instr_d = instr_q;
      pcd_d   = pcd_q;
      pcp4_d  = pcp4_q;
      valid_d = valid_q;
      if (FlushD || (!StallD && !load_c)) begin
         instr_d = NOP;
         pcd_d   = '0;
         pcp4_d  = '0;
         valid_d = 1'b0;
      end else if (!StallD) begin
         instr_d = load_word_c;
         pcd_d   = pc_pend_q;
         pcp4_d  = pc_pend_q + FOUR;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pcf_q     <= RESET_PC;
         discard_q <= 1'b0;
         instr_q   <= NOP;
         pcd_q     <= '0;
         pcp4_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pcf_q     <= pcf_d;
         discard_q <= discard_d;
         instr_q   <= instr_d;
         pcd_q     <= pcd_d;
         pcp4_q    <= pcp4_d;
         valid_q   <= valid_d;
      end
   end

   // Pending PC and skid word are only read when the FSM says they are valid.
   always_ff @(posedge clk) begin
      pc_pend_q <= pc_pend_d;
      skid_q    <= skid_d;
   end

   assign imem_req  = req_c;
   assign imem_addr = pcf_q;
   assign instrD    = instr_q;
   assign PCD       = pcd_q;
   assign PCPlus4D  = pcp4_q;
   assign validD    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run checked
// against a program-order PC model and a single-slot memory responder.
module tb_fetch_stage;

   localparam logic [31:0] KEY = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk, rst_n, StallF, StallD, FlushD, PCSrcE;
   logic [31:0] PCTargetE, imem_addr, imem_rdata, instrD, PCD, PCPlus4D;
   logic        imem_req, imem_gnt, imem_rvalid, validD;

   int          n_chk, n_fail;
   int unsigned gnt_pct, lat_min, lat_max;
   bit          rsp_busy;
   logic [31:0] rsp_addr;
   int          rsp_cnt;
   logic [31:0] hs_log[$];

   fetch_stage #(.DATA_WIDTH(32), .RESET_PC(RPC)) dut (
      .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
      .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instrD(instrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .validD(validD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock cycle: pick grant, note the handshake, step the responder.
   task automatic tick();
      bit          hs;
      logic [31:0] a;
      imem_gnt = ($urandom_range(0, 99) < gnt_pct);
      #1;
      hs = imem_req && imem_gnt;
      a  = imem_addr;
      @(posedge clk);
      #1;
      if (imem_rvalid) rsp_busy = 1'b0;
      else if (rsp_busy && rsp_cnt > 0) rsp_cnt--;
      if (hs) begin
         rsp_busy = 1'b1;
         rsp_addr = a;
         rsp_cnt  = int'($urandom_range(lat_min, lat_max)) - 1;
         hs_log.push_back(a);
      end
      imem_rvalid = rsp_busy && (rsp_cnt == 0);
      imem_rdata  = imem_rvalid ? (rsp_addr ^ KEY) : $urandom;
   endtask

   task automatic clear_inputs();
      StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst_n = 1'b0;
      rsp_busy = 1'b0; imem_rvalid = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      hs_log.delete();
   endtask

   task automatic test_reset();
      clear_inputs();
      gnt_pct = 100; lat_min = 1; lat_max = 1;
      rst_n = 1'b0;
      tick(); tick();
      n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
      n_chk++; if (imem_addr !== RPC) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RPC); end
      n_chk++; if (instrD !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", instrD, NOP); end
      n_chk++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin n_fail++; $display("FAIL reset_pcd: got %h/%h expected 0/0", PCD, PCPlus4D); end
      n_chk++; if (validD !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", validD); end
      rst_n = 1'b1;
      #1;
      n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_release_req: got %b expected 0", imem_req); end
      tick();
      n_chk++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin n_fail++; $display("FAIL reset_first_req: got %b/%h expected 1/%h", imem_req, imem_addr, RPC); end
   endtask

   task automatic test_stream();
      logic [31:0] pcs[4], ins[4];
      int got = 0;
      apply_reset();
      gnt_pct = 100; lat_min = 1; lat_max = 1;
      for (int c = 0; c < 40 && got < 4; c++) begin
         tick();
         if (validD) begin pcs[got] = PCD; ins[got] = instrD; got++; end
      end
      n_chk++; if (got != 4) begin n_fail++; $display("FAIL stream_count: got %0d expected 4", got); end
      for (int i = 0; i < got; i++) begin
         logic [31:0] e, h;
         e = 32'(4 * i);
         h = (hs_log.size() > i) ? hs_log[i] : 32'hxxxx_xxxx;
         n_chk++; if (h !== e) begin n_fail++; $display("FAIL stream_addr[%0d]: got %h expected %h", i, h, e); end
         n_chk++; if (pcs[i] !== e) begin n_fail++; $display("FAIL stream_pcd[%0d]: got %h expected %h", i, pcs[i], e); end
         n_chk++; if (ins[i] !== (e ^ KEY)) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, ins[i], e ^ KEY); end
      end
   endtask

   task automatic test_stall_skid();
      logic [31:0] s_i, s_p, s_p4;
      logic        s_v;
      bit          seen = 0;
      apply_reset();
      gnt_pct = 100; lat_min = 1; lat_max = 1;
      for (int c = 0; c < 40 && hs_log.size() < 3; c++) tick();
      n_chk++; if (hs_log.size() < 3 || hs_log[2] !== 32'h8) begin n_fail++; $display("FAIL skid_grant8: got %0d grants expected addr 8 granted", hs_log.size()); end
      s_i = instrD; s_p = PCD; s_p4 = PCPlus4D; s_v = validD;
      StallD = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_chk++; if ({instrD, PCD, PCPlus4D, validD} !== {s_i, s_p, s_p4, s_v}) begin n_fail++; $display("FAIL skid_frozen[%0d]: got %h/%h/%h/%b expected %h/%h/%h/%b", k, instrD, PCD, PCPlus4D, validD, s_i, s_p, s_p4, s_v); end
         n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL skid_noreq[%0d]: got %b expected 0", k, imem_req); end
      end
      StallD = 0;
      tick();
      n_chk++; if (instrD !== (32'h8 ^ KEY) || PCD !== 32'h8 || PCPlus4D !== 32'hC || validD !== 1'b1) begin n_fail++; $display("FAIL skid_release: got %h/%h/%h/%b expected %h/8/c/1", instrD, PCD, PCPlus4D, validD, 32'h8 ^ KEY); end
      for (int c = 0; c < 20 && !seen; c++) begin
         tick();
         if (validD) begin
            seen = 1;
            n_chk++; if (PCD !== 32'hC) begin n_fail++; $display("FAIL skid_next_pcd: got %h expected c", PCD); end
         end
      end
      n_chk++; if (!seen) begin n_fail++; $display("FAIL skid_next_timeout: got none expected delivery"); end
   endtask

   task automatic test_redirect();
      bit seen = 0;
      apply_reset();
      gnt_pct = 100; lat_min = 3; lat_max = 3;
      for (int c = 0; c < 40 && hs_log.size() < 2; c++) tick();
      PCSrcE = 1; PCTargetE = 32'h100; FlushD = 1;
      tick();
      clear_inputs();
      n_chk++; if (instrD !== NOP || validD !== 1'b0 || PCD !== 32'h0 || PCPlus4D !== 32'h0) begin n_fail++; $display("FAIL redir_bubble: got %h/%b/%h/%h expected %h/0/0/0", instrD, validD, PCD, PCPlus4D, NOP); end
      for (int c = 0; c < 30 && !seen; c++) begin
         tick();
         if (validD) begin
            seen = 1;
            n_chk++; if (PCD !== 32'h100) begin n_fail++; $display("FAIL redir_first_pcd: got %h expected 100", PCD); end
         end
      end
      n_chk++; if (!seen || hs_log.size() < 3 || hs_log[2] !== 32'h100) begin n_fail++; $display("FAIL redir_next_addr: got %0d grants expected third at 100", hs_log.size()); end
   endtask

   task automatic test_gnt_low();
      bit seen = 0;
      apply_reset();
      gnt_pct = 0; lat_min = 1; lat_max = 1;
      tick();
      n_chk++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin n_fail++; $display("FAIL gntlow_req: got %b/%h expected 1/%h", imem_req, imem_addr, RPC); end
      tick();
      PCSrcE = 1; PCTargetE = 32'h200;
      tick();
      clear_inputs();
      n_chk++; if (imem_addr !== 32'h200 || imem_req !== 1'b1) begin n_fail++; $display("FAIL gntlow_addr: got %b/%h expected 1/200", imem_req, imem_addr); end
      tick(); tick();
      gnt_pct = 100;
      for (int c = 0; c < 20 && !seen; c++) begin
         tick();
         if (validD) begin
            seen = 1;
            n_chk++; if (PCD !== 32'h200) begin n_fail++; $display("FAIL gntlow_pcd: got %h expected 200", PCD); end
         end
      end
      n_chk++; if (hs_log.size() < 1 || hs_log[0] !== 32'h200) begin n_fail++; $display("FAIL gntlow_first_grant: got %0d grants expected first at 200", hs_log.size()); end
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      apply_reset();
      gnt_pct = 100; lat_min = 4; lat_max = 4;
      for (int c = 0; c < 20 && hs_log.size() < 1; c++) tick();
      gnt_pct = 0;
      tick();
      rst_n = 1'b0;
      #1;
      n_chk++; if (imem_req !== 1'b0 || imem_addr !== RPC) begin n_fail++; $display("FAIL rstmid_req: got %b/%h expected 0/%h", imem_req, imem_addr, RPC); end
      n_chk++; if (instrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h0 || validD !== 1'b0) begin n_fail++; $display("FAIL rstmid_ifid: got %h/%h/%h/%b expected %h/0/0/0", instrD, PCD, PCPlus4D, validD, NOP); end
      tick();
      rst_n = 1'b1;
      hs_log.delete();
      for (int k = 0; k < 4; k++) begin
         tick();
         n_chk++; if (validD !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale[%0d]: got %b expected 0", k, validD); end
      end
      gnt_pct = 100; lat_min = 1; lat_max = 1;
      for (int c = 0; c < 20 && !seen; c++) begin
         tick();
         if (validD) begin
            seen = 1;
            n_chk++; if (PCD !== RPC || instrD !== (RPC ^ KEY)) begin n_fail++; $display("FAIL rstmid_first: got %h/%h expected %h/%h", PCD, instrD, RPC, RPC ^ KEY); end
         end
      end
      n_chk++; if (hs_log.size() < 1 || hs_log[0] !== RPC) begin n_fail++; $display("FAIL rstmid_first_addr: got %0d grants expected first at %h", hs_log.size(), RPC); end
   endtask

   task automatic test_wrap();
      bit seen = 0;
      apply_reset();
      gnt_pct = 100; lat_min = 1; lat_max = 1;
      StallF = 1; PCSrcE = 1; PCTargetE = 32'hFFFF_FFFC;
      tick();
      clear_inputs();
      for (int c = 0; c < 20 && !seen; c++) begin
         tick();
         if (validD) begin
            seen = 1;
            n_chk++; if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 || instrD !== (32'hFFFF_FFFC ^ KEY)) begin n_fail++; $display("FAIL wrap_ifid: got %h/%h/%h expected fffffffc/0/%h", PCD, PCPlus4D, instrD, 32'hFFFF_FFFC ^ KEY); end
         end
      end
      for (int c = 0; c < 20 && hs_log.size() < 2; c++) tick();
      n_chk++; if (hs_log.size() < 2 || hs_log[0] !== 32'hFFFF_FFFC || hs_log[1] !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %0d grants expected fffffffc then 0", hs_log.size()); end
   endtask

   // Deliveries must follow program order from the last redirect target.
   task automatic test_random();
      logic [31:0] exp_pc, s_i, s_p, s_p4, tgt;
      logic        s_v;
      bit          redir, p_sd, p_fl;
      int          deliveries = 0;
      apply_reset();
      gnt_pct = 60; lat_min = 1; lat_max = 3;
      exp_pc = RPC;
      s_i = instrD; s_p = PCD; s_p4 = PCPlus4D; s_v = validD;
      for (int c = 0; c < 800; c++) begin
         redir     = ($urandom_range(0, 99) < 5);
         tgt       = $urandom & 32'h0000_FFFC;
         StallF    = ($urandom_range(0, 99) < 20);
         StallD    = ($urandom_range(0, 99) < 25);
         PCSrcE    = redir;
         FlushD    = redir;
         PCTargetE = tgt;
         #1;
         if (StallF) begin
            n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rnd_req_stallf[%0d]: got %b expected 0", c, imem_req); end
         end
         p_sd = StallD; p_fl = FlushD;
         tick();
         if (!p_fl && p_sd) begin
            n_chk++; if ({instrD, PCD, PCPlus4D, validD} !== {s_i, s_p, s_p4, s_v}) begin n_fail++; $display("FAIL rnd_hold[%0d]: got %h/%h/%h/%b expected %h/%h/%h/%b", c, instrD, PCD, PCPlus4D, validD, s_i, s_p, s_p4, s_v); end
         end else if (!p_fl && validD) begin
            n_chk++; if (PCD !== exp_pc || instrD !== (exp_pc ^ KEY) || PCPlus4D !== exp_pc + 32'd4) begin n_fail++; $display("FAIL rnd_deliver[%0d]: got %h/%h/%h expected %h/%h/%h", c, PCD, instrD, PCPlus4D, exp_pc, exp_pc ^ KEY, exp_pc + 32'd4); end
            exp_pc = exp_pc + 32'd4;
            deliveries++;
         end else begin
            n_chk++; if (instrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h0 || validD !== 1'b0) begin n_fail++; $display("FAIL rnd_bubble[%0d]: got %h/%h/%h/%b expected %h/0/0/0", c, instrD, PCD, PCPlus4D, validD, NOP); end
         end
         if (redir) exp_pc = tgt;
         s_i = instrD; s_p = PCD; s_p4 = PCPlus4D; s_v = validD;
      end
      clear_inputs();
      n_chk++; if (deliveries < 20) begin n_fail++; $display("FAIL rnd_progress: got %0d deliveries expected at least 20", deliveries); end
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      rst_n = 1'b0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
      rsp_busy = 0; rsp_addr = '0; rsp_cnt = 0;
      gnt_pct = 100; lat_min = 1; lat_max = 1;
      clear_inputs();
      test_reset();
      test_stream();
      test_stall_skid();
      test_redirect();
      test_gnt_low();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
